// File: rtl/flags_pkg.sv
// Shared flag definitions for the flags register and its context stack.
package flags_pkg;

  localparam int FLAG_WIDTH_DEFAULT = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [FLAG_WIDTH_DEFAULT-1:0] flags_t;

endpackage

// File: rtl/flags_stack.sv
// LIFO of saved flag contexts with depth tracking and in-place exchange of the top entry.
module flags_stack #(
  parameter int FLAG_WIDTH  = 4,
  parameter int STACK_DEPTH = 4,
  localparam int DW = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [FLAG_WIDTH-1:0] wr_data,
  output logic [FLAG_WIDTH-1:0] rd_data,
  output logic [DW-1:0]         depth,
  output logic                  full,
  output logic                  empty
);

  logic [FLAG_WIDTH-1:0] entries [STACK_DEPTH];
  logic [DW-1:0]         top_idx;
  logic [DW-1:0]         wr_idx;

  assign full    = (depth == DW'(STACK_DEPTH));
  assign empty   = (depth == '0);
  assign top_idx = depth - DW'(1);

  // Push+pop together rewrites the current top; a plain push fills the next free slot.
  assign wr_idx  = pop ? top_idx : depth;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (DW'(i) == top_idx) rd_data = entries[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      depth <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) entries[i] <= '0;
    end else begin
      if (push) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
          if (DW'(i) == wr_idx) entries[i] <= wr_data;
        end
      end
      if (push && !pop)      depth <= depth + DW'(1);
      else if (pop && !push) depth <= depth - DW'(1);
    end
  end

endmodule

// File: rtl/flags_context_register.sv
// ALU status flags with masked writes, a save/restore context stack and sticky misuse errors.
module flags_context_register
  import flags_pkg::*;
#(
  parameter int FLAG_WIDTH  = FLAG_WIDTH_DEFAULT,
  parameter int STACK_DEPTH = 4,
  localparam int DW = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flags_reg_write_enable,
  input  logic [FLAG_WIDTH-1:0] write_mask,
  input  logic [FLAG_WIDTH-1:0] d,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  err_clear,
  output logic [FLAG_WIDTH-1:0] q,
  output logic [DW-1:0]         depth,
  output logic                  stack_full,
  output logic                  stack_empty,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  logic                  stk_push;
  logic                  stk_pop;
  logic                  overflow_ev;
  logic                  underflow_ev;
  logic [FLAG_WIDTH-1:0] stk_top;
  logic [FLAG_WIDTH-1:0] q_next;

  // Pop only takes effect when something is saved; push may proceed if it is an exchange or there is room.
  assign stk_pop      = pop && !stack_empty;
  assign stk_push     = push && (stk_pop || !stack_full);
  assign overflow_ev  = push && !pop && stack_full;
  assign underflow_ev = pop && !push && stack_empty;

  flags_stack #(
    .FLAG_WIDTH  (FLAG_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .push    (stk_push),
    .pop     (stk_pop),
    .wr_data (q),
    .rd_data (stk_top),
    .depth   (depth),
    .full    (stack_full),
    .empty   (stack_empty)
  );

  always_comb begin
    q_next = q;
    if (stk_pop)                     q_next = stk_top;
    else if (flags_reg_write_enable) q_next = (q & ~write_mask) | (d & write_mask);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q             <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      q             <= q_next;
      overflow_err  <= overflow_ev  || (overflow_err  && !err_clear);
      underflow_err <= underflow_ev || (underflow_err && !err_clear);
    end
  end

endmodule

// File: tb/tb_flags_context_register.sv
// Randomised bench comparing flags_context_register against a queue-based context model.
module tb_flags_context_register;
  import flags_pkg::*;

  localparam int SD = 4;
  localparam int DW = $clog2(SD + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          flags_reg_write_enable;
  flags_t        write_mask;
  flags_t        d;
  logic          push;
  logic          pop;
  logic          err_clear;
  flags_t        q;
  logic [DW-1:0] depth;
  logic          stack_full;
  logic          stack_empty;
  logic          overflow_err;
  logic          underflow_err;

  flags_t q_m;
  flags_t stk_m[$];
  bit     ov_m;
  bit     un_m;
  bit     cmp_en = 1'b0;
  int     checks = 0;
  int     failures = 0;

  always #5 clk = ~clk;

  flags_context_register #(
    .FLAG_WIDTH  (4),
    .STACK_DEPTH (SD)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .flags_reg_write_enable (flags_reg_write_enable),
    .write_mask             (write_mask),
    .d                      (d),
    .push                   (push),
    .pop                    (pop),
    .err_clear              (err_clear),
    .q                      (q),
    .depth                  (depth),
    .stack_full             (stack_full),
    .stack_empty            (stack_empty),
    .overflow_err           (overflow_err),
    .underflow_err          (underflow_err)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: saved contexts are a queue whose back is the top of stack.
  task automatic modelUpdate();
    flags_t t;
    bit     empty_m;
    bit     full_m;
    bit     ov_ev;
    bit     un_ev;
    if (!rst) begin
      q_m = '0;
      stk_m.delete();
      ov_m = 1'b0;
      un_m = 1'b0;
    end else begin
      empty_m = (stk_m.size() == 0);
      full_m  = (stk_m.size() == SD);
      ov_ev   = push && !pop && full_m;
      un_ev   = pop && !push && empty_m;
      if (pop && !empty_m) begin
        t = stk_m.pop_back();
        if (push) stk_m.push_back(q_m);
        q_m = t;
      end else begin
        if (push && !full_m) stk_m.push_back(q_m);
        if (flags_reg_write_enable) q_m = (q_m & ~write_mask) | (d & write_mask);
      end
      ov_m = ov_ev || (ov_m && !err_clear);
      un_m = un_ev || (un_m && !err_clear);
    end
  endtask

  task automatic applyStimulus(input bit we_i, input flags_t mask_i, input flags_t d_i,
                               input bit push_i, input bit pop_i, input bit clr_i, input bit rst_i);
    flags_reg_write_enable = we_i;
    write_mask             = mask_i;
    d                      = d_i;
    push                   = push_i;
    pop                    = pop_i;
    err_clear              = clr_i;
    rst                    = rst_i;
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("q", int'(q), int'(q_m));
      checkOutput("depth", int'(depth), stk_m.size());
      checkOutput("stack_full", int'(stack_full), int'(stk_m.size() == SD));
      checkOutput("stack_empty", int'(stack_empty), int'(stk_m.size() == 0));
      checkOutput("overflow_err", int'(overflow_err), int'(ov_m));
      checkOutput("underflow_err", int'(underflow_err), int'(un_m));
    end
  end

  initial begin
    flags_reg_write_enable = 1'b0;
    write_mask = '0;
    d = '0;
    push = 1'b0;
    pop = 1'b0;
    err_clear = 1'b0;
    rst = 1'b0;
    q_m = '0;
    ov_m = 1'b0;
    un_m = 1'b0;

    applyStimulus(0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    applyStimulus(0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    cmp_en = 1'b1;
    checkOutput("reset_q", int'(q), 0);
    checkOutput("reset_depth", int'(depth), 0);
    checkOutput("reset_empty", int'(stack_empty), 1);
    checkOutput("reset_full", int'(stack_full), 0);

    // Masked writes
    applyStimulus(1, 4'b0101, 4'b1111, 0, 0, 0, 1);
    checkOutput("mask1_q", int'(q), 4'b0101);
    checkOutput("mask1_model", int'(q_m), 4'b0101);
    applyStimulus(1, 4'b0001, 4'b0000, 0, 0, 0, 1);
    checkOutput("mask2_q", int'(q), 4'b0100);

    // Push saves the pre-write value; pop wins over a write
    applyStimulus(1, 4'b1111, 4'b1010, 0, 0, 0, 1);
    applyStimulus(1, 4'b1111, 4'b0101, 1, 0, 0, 1);
    checkOutput("push_wr_q", int'(q), 4'b0101);
    checkOutput("push_wr_depth", int'(depth), 1);
    applyStimulus(1, 4'b1111, 4'b1111, 0, 1, 0, 1);
    checkOutput("pop_wr_q", int'(q), 4'b1010);
    checkOutput("pop_wr_depth", int'(depth), 0);

    // Fill the stack, overflow, then drain in LIFO order
    applyStimulus(1, 4'b1111, 4'd1, 0, 0, 0, 1);
    for (int v = 2; v <= 5; v++) applyStimulus(1, 4'b1111, flags_t'(v), 1, 0, 0, 1);
    applyStimulus(0, 4'b0000, 4'b0000, 1, 0, 0, 1);
    checkOutput("ovf_depth", int'(depth), 4);
    checkOutput("ovf_full", int'(stack_full), 1);
    checkOutput("ovf_err", int'(overflow_err), 1);
    checkOutput("ovf_q", int'(q), 5);
    checkOutput("ovf_model_err", int'(ov_m), 1);
    for (int v = 4; v >= 1; v--) begin
      applyStimulus(0, 4'b0000, 4'b0000, 0, 1, 0, 1);
      checkOutput("drain_q", int'(q), v);
    end
    checkOutput("drain_empty", int'(stack_empty), 1);
    applyStimulus(0, 4'b0000, 4'b0000, 0, 0, 1, 1);
    checkOutput("ovf_cleared", int'(overflow_err), 0);

    // Underflow still lets the write through
    applyStimulus(1, 4'b1111, 4'b0011, 0, 1, 0, 1);
    checkOutput("unf_err", int'(underflow_err), 1);
    checkOutput("unf_q", int'(q), 4'b0011);
    checkOutput("unf_depth", int'(depth), 0);
    applyStimulus(0, 4'b0000, 4'b0000, 0, 0, 1, 1);
    checkOutput("unf_cleared", int'(underflow_err), 0);

    // Exchange of q with the top entry
    applyStimulus(1, 4'b1111, 4'b1000, 0, 0, 0, 1);
    applyStimulus(1, 4'b1111, 4'b0001, 1, 0, 0, 1);
    applyStimulus(1, 4'b1111, 4'b1111, 1, 1, 0, 1);
    checkOutput("xchg_q", int'(q), 4'b1000);
    checkOutput("xchg_depth", int'(depth), 1);
    applyStimulus(0, 4'b0000, 4'b0000, 0, 1, 0, 1);
    checkOutput("xchg_top", int'(q), 4'b0001);

    // Reset during a push only acts on the clock edge
    applyStimulus(0, 4'b0000, 4'b0000, 1, 0, 0, 1);
    applyStimulus(0, 4'b0000, 4'b0000, 1, 0, 0, 1);
    push = 1'b1;
    rst = 1'b0;
    #2;
    checkOutput("rst_wait_q", int'(q), 4'b0001);
    checkOutput("rst_wait_depth", int'(depth), 2);
    @(posedge clk);
    modelUpdate();
    #1;
    checkOutput("rst_push_q", int'(q), 0);
    checkOutput("rst_push_depth", int'(depth), 0);
    checkOutput("rst_push_empty", int'(stack_empty), 1);
    checkOutput("rst_push_err", int'(overflow_err) + int'(underflow_err), 0);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 1) == 1, flags_t'($urandom), flags_t'($urandom),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 99) != 0);
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
